// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared ALU control codes, funct/opcode values and mul/div FSM states.
package mips_alu_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MADD = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_HILO = 4'b1100;
    localparam logic [3:0] ALU_NOR  = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SPEC2 = 6'h1C;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALU control decode plus HI/LO instruction classification.
module alu_ctrl_decode import mips_alu_pkg::*; #(
    parameter int ENABLE_DIV = 1
) (
    input  logic [1:0] ALUOp,
    input  logic [5:0] functcode,
    input  logic [5:0] opcode,
    output logic [3:0] alu_ctrl,
    output logic       illegal_op,
    output logic       is_muldiv,
    output logic       is_mt,
    output logic       is_mf
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal_op = 1'b0;
        is_muldiv = 1'b0;
        is_mt = 1'b0;
        is_mf = 1'b0;
        case (ALUOp)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_R: case (functcode)
                F_SLL, F_SLLV:   alu_ctrl = ALU_SLL;
                F_SRL, F_SRLV:   alu_ctrl = ALU_SRL;
                F_SRA, F_SRAV:   alu_ctrl = ALU_SRA;
                F_ADD, F_ADDU:   alu_ctrl = ALU_ADD;
                F_SUB, F_SUBU:   alu_ctrl = ALU_SUB;
                F_AND:           alu_ctrl = ALU_AND;
                F_OR:            alu_ctrl = ALU_OR;
                F_XOR:           alu_ctrl = ALU_XOR;
                F_NOR:           alu_ctrl = ALU_NOR;
                F_SLT:           alu_ctrl = ALU_SLT;
                F_SLTU:          alu_ctrl = ALU_SLTU;
                F_MFHI, F_MFLO:  begin alu_ctrl = ALU_HILO; is_mf = 1'b1; end
                F_MTHI, F_MTLO:  begin alu_ctrl = ALU_HILO; is_mt = 1'b1; end
                F_MULT, F_MULTU: begin alu_ctrl = ALU_HILO; is_muldiv = 1'b1; end
                F_DIV, F_DIVU:   if (ENABLE_DIV != 0) begin alu_ctrl = ALU_HILO; is_muldiv = 1'b1; end
                                 else illegal_op = 1'b1;
                default:         illegal_op = 1'b1;
            endcase
            default: case (opcode)
                OP_ADDI, OP_ADDIU: alu_ctrl = ALU_ADD;
                OP_ANDI:           alu_ctrl = ALU_AND;
                OP_ORI:            alu_ctrl = ALU_OR;
                OP_XORI:           alu_ctrl = ALU_XOR;
                OP_SLTI:           alu_ctrl = ALU_SLT;
                OP_SLTIU:          alu_ctrl = ALU_SLTU;
                OP_LUI:            alu_ctrl = ALU_LUI;
                OP_SPEC2:          alu_ctrl = (functcode != 6'd0) ? ALU_MUL : ALU_MADD;
                default:           illegal_op = 1'b1;
            endcase
        endcase
    end
endmodule

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: EX-stage ALU control decode with an iterative mul/div engine owning HI/LO.
module alu_muldiv_unit import mips_alu_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int ENABLE_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       functcode,
    input  logic [5:0]       opcode,
    output logic [3:0]       alu_ctrl,
    output logic             illegal_op,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_result,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    logic is_muldiv, is_mt, is_mf, accept, a_neg, b_neg, fits;
    logic div_op, neg_q, neg_r, b_zero;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2*WIDTH:0] acc, step_acc;
    logic [WIDTH-1:0] opb, a_mag, b_mag, quo, rem, quo_fix, rem_fix;
    logic [WIDTH:0] upper_m, sh_hi;
    logic [2*WIDTH-1:0] prod, prod_fix;

    alu_ctrl_decode #(.ENABLE_DIV(ENABLE_DIV)) u_dec (
        .ALUOp(ALUOp), .functcode(functcode), .opcode(opcode),
        .alu_ctrl(alu_ctrl), .illegal_op(illegal_op),
        .is_muldiv(is_muldiv), .is_mt(is_mt), .is_mf(is_mf)
    );

    assign accept    = op_valid && op_ready && is_muldiv;
    assign a_neg     = !functcode[0] && src_a[WIDTH-1];
    assign b_neg     = !functcode[0] && src_b[WIDTH-1];
    assign a_mag     = a_neg ? -src_a : src_a;
    assign b_mag     = b_neg ? -src_b : src_b;
    assign mf_result = is_mf ? (functcode[1] ? lo : hi) : '0;

    // acc = {partial product | remainder, multiplier | quotient}; one step per RUN cycle
    assign upper_m  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opb} : '0);
    assign sh_hi    = acc[2*WIDTH-1:WIDTH-1];
    assign fits     = sh_hi >= {1'b0, opb};
    assign step_acc = div_op ? {fits ? sh_hi - {1'b0, opb} : sh_hi, acc[WIDTH-2:0], fits}
                             : {1'b0, upper_m, acc[WIDTH-1:1]};

    assign prod     = acc[2*WIDTH-1:0];
    assign prod_fix = neg_q ? -prod : prod;
    assign quo      = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];
    // a zero divisor leaves the dividend magnitude as remainder, so the signed fix restores src_a
    assign quo_fix  = b_zero ? '1 : (neg_q ? -quo : quo);
    assign rem_fix  = neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_ready <= 1'b1;
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
            div_by_zero <= 1'b0;
            acc <= '0;
            cnt <= '0;
            opb <= '0;
            div_op <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state <= RUN;
                    op_ready <= 1'b0;
                    cnt <= CW'(WIDTH-1);
                    acc <= {{(WIDTH+1){1'b0}}, a_mag};
                    opb <= b_mag;
                    div_op <= (ENABLE_DIV != 0) && functcode[1];
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    b_zero <= src_b == '0;
                end else if (op_valid && is_mt) begin
                    if (functcode[1]) lo <= src_a;
                    else hi <= src_a;
                end
                RUN: begin
                    acc <= step_acc;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    {hi, lo} <= div_op ? {rem_fix, quo_fix} : prod_fix;
                    done <= 1'b1;
                    div_by_zero <= div_op && b_zero;
                    op_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
